// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared text-mode geometry, control codes and controller states
package vga_text_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  function automatic logic is_print(input logic [7:0] c);
    return c >= 8'h20 && c <= 8'h7E;
  endfunction
endpackage

// File: rtl/text_write_ctrl_if.sv
// text_write_ctrl_if: byte intake from the SPI receiver and framebuffer write port
interface text_write_ctrl_if #(parameter int ADDR_W = 12);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  modport master (input rx_data, rx_valid, wr_ready, output rx_ready, wr_en, wr_addr, wr_data);
  modport slave  (output rx_data, rx_valid, wr_ready, input rx_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/text_write_ctrl_cursor_counter.sv
// text_cursor_counter: cursor column/row and the framebuffer base address of the current row
module text_cursor_counter #(
  parameter int COLS   = vga_text_pkg::COLS,
  parameter int ROWS   = vga_text_pkg::ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              back,
  input  logic              cr,
  input  logic              lf,
  input  logic              home,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] lf_base
);
  import vga_text_pkg::*;
  logic last_row;
  assign last_row = row == 5'(ROWS - 1);
  // base of the row a line advance lands on; lets the caller start its clear without a multiplier
  assign lf_base = last_row ? '0 : row_base + ADDR_W'(COLS);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (lf) begin
      col      <= '0;
      row      <= last_row ? '0 : row + 5'd1;
      row_base <= lf_base;
    end else if (cr) col <= '0;
    else if (inc) col <= col + 7'd1;
    else if (back) col <= col - 7'd1;
endmodule

// File: rtl/text_write_ctrl.sv
// text_write_ctrl: decodes received bytes into framebuffer cell writes and row/screen clears.
// Optional cursor blink under `define TEXT_CURSOR_BLINK_EN.
module text_write_ctrl #(
  parameter int COLS         = vga_text_pkg::COLS,
  parameter int ROWS         = vga_text_pkg::ROWS,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  text_write_ctrl_if.master     bus,
  input  logic                  frame_tick,
  output logic [6:0]            cursor_col,
  output logic [4:0]            cursor_row,
  output logic                  busy,
  output logic                  cursor_on
);
  import vga_text_pkg::*;
  state_t state, nstate;
  logic [ADDR_W-1:0] clr_end, n_end, n_addr, row_base, lf_base, cur_addr;
  logic [7:0] n_data;
  logic n_en, adv, n_adv, home_pend, n_home;
  logic inc, back, cr, lf, home, start_lf, xfer, take;

  text_cursor_counter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk, .rst, .inc, .back, .cr, .lf, .home,
    .col(cursor_col), .row(cursor_row), .row_base, .lf_base
  );

  assign cur_addr     = row_base + ADDR_W'(cursor_col);
  assign bus.rx_ready = state == IDLE && !rst;
  assign busy         = state != IDLE;
  assign take         = bus.rx_valid && bus.rx_ready;
  assign xfer         = bus.wr_en && bus.wr_ready;

  always_comb begin
    nstate   = state;
    n_en     = bus.wr_en;
    n_addr   = bus.wr_addr;
    n_data   = bus.wr_data;
    n_end    = clr_end;
    n_adv    = adv;
    n_home   = home_pend;
    inc      = 1'b0;
    back     = 1'b0;
    cr       = 1'b0;
    lf       = 1'b0;
    home     = 1'b0;
    start_lf = 1'b0;
    case (state)
      IDLE:
        if (take) begin
          if (is_print(bus.rx_data)) begin
            nstate = WRITE;
            n_en   = 1'b1;
            n_addr = cur_addr;
            n_data = bus.rx_data;
            n_adv  = 1'b1;
          end else if (bus.rx_data == CH_CR) cr = 1'b1;
          else if (bus.rx_data == CH_LF) start_lf = 1'b1;
          else if (bus.rx_data == CH_BS && cursor_col != '0) begin
            back   = 1'b1;
            nstate = WRITE;
            n_en   = 1'b1;
            n_addr = cur_addr - ADDR_W'(1);
            n_data = CH_SPACE;
            n_adv  = 1'b0;
          end else if (bus.rx_data == CH_FF) begin
            nstate = CLEAR;
            n_en   = 1'b1;
            n_addr = '0;
            n_data = CH_SPACE;
            n_end  = ADDR_W'(COLS * ROWS - 1);
            n_home = 1'b1;
          end
        end
      WRITE:
        if (xfer) begin
          n_en   = 1'b0;
          nstate = IDLE;
          if (adv && cursor_col == 7'(COLS - 1)) start_lf = 1'b1;
          else if (adv) inc = 1'b1;
        end
      CLEAR:
        if (xfer) begin
          if (bus.wr_addr == clr_end) begin
            n_en   = 1'b0;
            nstate = IDLE;
            home   = home_pend;
          end else n_addr = bus.wr_addr + ADDR_W'(1);
        end
      default: nstate = IDLE;
    endcase
    // line advance moves the cursor now and blanks the destination row
    if (start_lf) begin
      lf     = 1'b1;
      nstate = CLEAR;
      n_en   = 1'b1;
      n_addr = lf_base;
      n_data = CH_SPACE;
      n_end  = lf_base + ADDR_W'(COLS - 1);
      n_home = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      clr_end     <= '0;
      adv         <= 1'b0;
      home_pend   <= 1'b0;
    end else begin
      state       <= nstate;
      bus.wr_en   <= n_en;
      bus.wr_addr <= n_addr;
      bus.wr_data <= n_data;
      clr_end     <= n_end;
      adv         <= n_adv;
      home_pend   <= n_home;
    end

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic blink_wrap;
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      blink_cnt <= '0;
      cursor_on <= 1'b0;
    end else if (inc || back || cr || lf || home) begin
      blink_cnt <= '0;
      cursor_on <= 1'b1;
    end else if (frame_tick) begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      cursor_on <= blink_wrap ? ~cursor_on : cursor_on;
    end
`else
  localparam int unused_blink = BLINK_FRAMES;
  logic unused_tick;
  assign unused_tick = frame_tick;
  assign cursor_on   = 1'b0;
`endif
endmodule

// File: tb/tb_text_write_ctrl.sv
// tb_text_write_ctrl: directed byte stream with a write scoreboard checked by an independent monitor
module tb_text_write_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic busy, cursor_on;
  text_write_ctrl_if #(.ADDR_W(12)) bus();
  text_write_ctrl #(.COLS(80), .ROWS(30), .ADDR_W(12), .BLINK_FRAMES(30)) dut (
    .clk(clk), .rst(rst), .bus(bus), .frame_tick(frame_tick),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy), .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int n_writes = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  logic toggle = 1'b0;
  logic stall_prev = 1'b0;
  logic [11:0] held_addr;
  logic [7:0] held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // framebuffer side: accepts every cycle, or alternates 1/0 when toggle is set
  always @(posedge clk) begin
    #1;
    bus.wr_ready = toggle ? ~bus.wr_ready : 1'b1;
  end

  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      check("stall_en", bus.wr_en, 1);
      check("stall_addr", bus.wr_addr, held_addr);
      check("stall_data", bus.wr_data, held_data);
    end
    if (bus.wr_en && bus.wr_ready && !rst) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, mon_e[19:8]);
        check("wr_data", bus.wr_data, mon_e[7:0]);
      end
    end
    stall_prev = bus.wr_en && !bus.wr_ready && !rst;
    held_addr  = bus.wr_addr;
    held_data  = bus.wr_data;
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!bus.rx_ready && t < 10000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10000) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: rx_ready 0 expected 1 for byte %0h", b);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_ready && n < 10000);
    if (n >= 10000) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout: rx_ready 0 expected 1");
    end
  endtask

  task automatic push_clear(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back({12'(base + i), 8'h20});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, t;
    logic [7:0] c;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor_on", cursor_on, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", bus.rx_ready, 1);

    exp_q.push_back({12'd0, 8'h41});
    send(8'h41);
    @(negedge clk);
    check("a_wr_en_n1", bus.wr_en, 1);
    check("a_rx_ready_n1", bus.rx_ready, 0);
    @(negedge clk);
    check("a_rx_ready_n2", bus.rx_ready, 1);
    check("a_col", cursor_col, 1);

    send(8'h0D);
    @(negedge clk);
    check("cr_col", cursor_col, 0);
    for (int i = 0; i < 80; i++) begin
      c = 8'h21 + 8'(i);
      exp_q.push_back({12'(i), c});
      send(c);
    end
    push_clear(80, 80);
    wait_ready(n);
    check("row_col", cursor_col, 0);
    check("row_row", cursor_row, 1);

    for (int r = 1; r < 29; r++) begin
      push_clear((r + 1) * 80, 80);
      send(8'h0A);
    end
    wait_ready(n);
    check("lf29_row", cursor_row, 29);
    push_clear(0, 80);
    send(8'h0A);
    wait_ready(n);
    check("lf_wrap_latency", n, 81);
    check("lf_wrap_col", cursor_col, 0);
    check("lf_wrap_row", cursor_row, 0);

    exp_q.push_back({12'd0, 8'h42});
    send(8'h42);
    wait_ready(n);
    check("b_latency", n, 2);
    check("b_col", cursor_col, 1);
    toggle = 1'b1;
    push_clear(0, 2400);
    send(8'h0C);
    wait_ready(n);
    toggle = 1'b0;
    check("ff_col", cursor_col, 0);
    check("ff_row", cursor_row, 0);
    check("ff_drained", exp_q.size(), 0);

    send(8'h08);
    repeat (3) @(negedge clk);
    check("bs0_busy", busy, 0);
    check("bs0_col", cursor_col, 0);
    check("bs0_row", cursor_row, 0);
    check("bs0_no_write", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({12'(i), hello[i]});
      send(hello[i]);
    end
    wait_ready(n);
    check("hello_col", cursor_col, 5);
    exp_q.push_back({12'd4, 8'h20});
    send(8'h08);
    wait_ready(n);
    check("bs5_col", cursor_col, 4);
    check("bs5_row", cursor_row, 0);

    base = n_writes;
    push_clear(0, 100);
    send(8'h0C);
    t = 0;
    while (n_writes < base + 100 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) begin
      vectors++;
      errors++;
      $display("FAIL ff_reset_timeout: writes %0d expected %0d", n_writes - base, 100);
    end
    #1 rst = 1'b1;
    #1;
    check("abort_wr_en", bus.wr_en, 0);
    check("abort_col", cursor_col, 0);
    check("abort_row", cursor_row, 0);
    check("abort_busy", busy, 0);
    check("abort_rx_ready", bus.rx_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rx_ready_after", bus.rx_ready, 1);
    repeat (200) @(negedge clk);
    check("abort_write_count", n_writes - base, 100);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_cursor_on", cursor_on, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
